// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the RAM macro.
// slave = arbiter side; master = requesters plus RAM model side.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic          p0_lock;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;

  logic          p1_req;
  logic          p1_we;
  logic          p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port block RAM: one access per cycle,
// round-robin or fixed priority, locked bursts, owner-tagged read returns.
//
// state | meaning
// IDLE  | no lock held, arbitrate between p0 and p1
// LOCK0 | p0 holds the RAM, p1 is blocked
// LOCK1 | p1 holds the RAM, p0 is blocked
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int READ_LAT = 1,
  parameter int RR       = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t              state;
  logic                last;
  logic                pick0;
  logic                gnt0;
  logic                gnt1;
  logic                rd_issue;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       din_q;
  logic [READ_LAT-1:0] pipe_vld;
  logic [READ_LAT-1:0] pipe_own;

  // last=1 means p1 was served most recently, so p0 gets the next tie
  always_comb begin
    pick0 = (RR != 0) ? last : 1'b1;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.p0_req && bus.p1_req) begin
            gnt0 = pick0;
            gnt1 = !pick0;
          end else begin
            gnt0 = bus.p0_req;
            gnt1 = bus.p1_req;
          end
        end
        LOCK0:   gnt0 = bus.p0_req;
        LOCK1:   gnt1 = bus.p1_req;
        default: ;
      endcase
    end
  end

  assign rd_issue = (gnt0 && !bus.p0_we) || (gnt1 && !bus.p1_we);

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.mem_we    = (gnt0 && bus.p0_we) || (gnt1 && bus.p1_we);
  assign bus.mem_addr  = gnt0 ? bus.p0_addr  : (gnt1 ? bus.p1_addr  : addr_q);
  assign bus.mem_din   = gnt0 ? bus.p0_wdata : (gnt1 ? bus.p1_wdata : din_q);
  assign bus.rdata     = bus.mem_dout;
  assign bus.p0_rvalid = pipe_vld[READ_LAT-1] && !pipe_own[READ_LAT-1];
  assign bus.p1_rvalid = pipe_vld[READ_LAT-1] &&  pipe_own[READ_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      addr_q   <= '0;
      din_q    <= '0;
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      addr_q <= bus.mem_addr;
      din_q  <= bus.mem_din;

      if (gnt0)      last <= 1'b0;
      else if (gnt1) last <= 1'b1;

      // owner tag travels alongside valid so returns keep grant order
      pipe_vld[0] <= rd_issue;
      pipe_own[0] <= gnt1;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end

      case (state)
        IDLE: begin
          if (gnt0 && bus.p0_lock)      state <= LOCK0;
          else if (gnt1 && bus.p1_lock) state <= LOCK1;
        end
        LOCK0: if (!bus.p0_req || (gnt0 && !bus.p0_lock)) state <= IDLE;
        LOCK1: if (!bus.p1_req || (gnt1 && !bus.p1_lock)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover RR=1/LAT=1,
// RR=0/LAT=1 and RR=1/LAT=2, each with a behavioural RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(8), .DW(32)) ifa ();
  mem_arbiter_if #(.AW(8), .DW(32)) ifb ();
  mem_arbiter_if #(.AW(8), .DW(32)) ifc ();

  mem_arbiter #(.AW(8), .DW(32), .READ_LAT(1), .RR(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_arbiter #(.AW(8), .DW(32), .READ_LAT(1), .RR(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mem_arbiter #(.AW(8), .DW(32), .READ_LAT(2), .RR(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [31:0] ram_c [256];
  logic [31:0] dly_c;

  always @(posedge clk) begin
    if (ifa.mem_we) ram_a[ifa.mem_addr] <= ifa.mem_din;
    ifa.mem_dout <= ram_a[ifa.mem_addr];
    if (ifb.mem_we) ram_b[ifb.mem_addr] <= ifb.mem_din;
    ifb.mem_dout <= ram_b[ifb.mem_addr];
    if (ifc.mem_we) ram_c[ifc.mem_addr] <= ifc.mem_din;
    dly_c        <= ram_c[ifc.mem_addr];
    ifc.mem_dout <= dly_c;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ifa.p0_req = 0; ifa.p0_we = 0; ifa.p0_lock = 0; ifa.p0_addr = 0; ifa.p0_wdata = 0;
    ifa.p1_req = 0; ifa.p1_we = 0; ifa.p1_lock = 0; ifa.p1_addr = 0; ifa.p1_wdata = 0;
    ifb.p0_req = 0; ifb.p0_we = 0; ifb.p0_lock = 0; ifb.p0_addr = 0; ifb.p0_wdata = 0;
    ifb.p1_req = 0; ifb.p1_we = 0; ifb.p1_lock = 0; ifb.p1_addr = 0; ifb.p1_wdata = 0;
    ifc.p0_req = 0; ifc.p0_we = 0; ifc.p0_lock = 0; ifc.p0_addr = 0; ifc.p0_wdata = 0;
    ifc.p1_req = 0; ifc.p1_we = 0; ifc.p1_lock = 0; ifc.p1_addr = 0; ifc.p1_wdata = 0;

    // grants must stay low while reset is held, even with a request up
    ifa.p0_req = 1; ifa.p0_addr = 8'h33;
    tick(); tick(); mid();
    chk("rst_gnt0",     ifa.p0_gnt,    0);
    chk("rst_gnt1",     ifa.p1_gnt,    0);
    chk("rst_rvalid0",  ifa.p0_rvalid, 0);
    chk("rst_mem_we",   ifa.mem_we,    0);
    chk("rst_mem_addr", ifa.mem_addr,  0);

    // preload 0x05 through p1
    tick(); rst = 1'b0; ifa.p0_req = 0; ifa.p0_addr = 0;
    ifa.p1_req = 1; ifa.p1_we = 1; ifa.p1_addr = 8'h05; ifa.p1_wdata = 32'hDEADBEEF;
    mid();
    chk("pre_gnt1",   ifa.p1_gnt, 1);
    chk("pre_mem_we", ifa.mem_we, 1);
    tick(); ifa.p1_req = 0; ifa.p1_we = 0;

    // reset lands on a read in flight
    ifa.p0_req = 1; ifa.p0_addr = 8'h10;
    mid();
    chk("mr_gnt0", ifa.p0_gnt,   1);
    chk("mr_addr", ifa.mem_addr, 32'h10);
    tick(); ifa.p0_req = 0; rst = 1'b1;
    mid();
    chk("mr_rvalid0",  ifa.p0_rvalid, 0);
    chk("mr_rvalid1",  ifa.p1_rvalid, 0);
    chk("mr_gnt0_rst", ifa.p0_gnt,    0);
    chk("mr_mem_we",   ifa.mem_we,    0);
    chk("mr_mem_addr", ifa.mem_addr,  0);
    chk("mr_mem_din",  ifa.mem_din,   0);
    tick(); rst = 1'b0;
    mid();
    chk("mr_rvalid_after", ifa.p0_rvalid, 0);

    // single p0 read
    tick(); ifa.p0_req = 1; ifa.p0_addr = 8'h05;
    mid();
    chk("sr_gnt0", ifa.p0_gnt,   1);
    chk("sr_gnt1", ifa.p1_gnt,   0);
    chk("sr_addr", ifa.mem_addr, 32'h05);
    tick(); ifa.p0_req = 0;
    mid();
    chk("sr_rvalid0", ifa.p0_rvalid, 1);
    chk("sr_rdata",   ifa.rdata,     32'hDEADBEEF);
    chk("sr_rvalid1", ifa.p1_rvalid, 0);
    tick(); mid();
    chk("sr_pulse", ifa.p0_rvalid, 0);

    // locked p1 write burst while p0 keeps asking (last=p0, so p1 wins first)
    tick(); ifa.p0_req = 1; ifa.p0_we = 0; ifa.p0_addr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ifa.p1_req = 1; ifa.p1_we = 1; ifa.p1_lock = (i < 3);
      ifa.p1_addr = i[7:0]; ifa.p1_wdata = 32'hC0DE0000 + i;
      mid();
      chk("lk_gnt1", ifa.p1_gnt, 1);
      chk("lk_gnt0", ifa.p0_gnt, 0);
      tick();
    end
    ifa.p1_req = 0; ifa.p1_we = 0; ifa.p1_lock = 0;
    for (int i = 0; i < 4; i++) begin
      ifa.p0_addr = i[7:0];
      mid();
      chk("rb_gnt0", ifa.p0_gnt, 1);
      if (i > 0) begin
        chk("rb_rvalid0", ifa.p0_rvalid, 1);
        chk("rb_rdata",   ifa.rdata,     32'hC0DE0000 + i - 1);
      end
      tick();
    end
    ifa.p0_req = 0;
    mid();
    chk("rb_rvalid0_last", ifa.p0_rvalid, 1);
    chk("rb_rdata_last",   ifa.rdata,     32'hC0DE0003);

    // contention from reset: RR on dut_a, fixed priority on dut_b
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    ifa.p0_req = 1; ifa.p1_req = 1; ifa.p0_addr = 8'h00; ifa.p1_addr = 8'h01;
    ifb.p0_req = 1; ifb.p1_req = 1; ifb.p0_addr = 8'h00; ifb.p1_addr = 8'h01;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("ca_gnt0", ifa.p0_gnt, (k % 2) == 0);
      chk("ca_gnt1", ifa.p1_gnt, (k % 2) == 1);
      chk("cb_gnt0", ifb.p0_gnt, 1);
      chk("cb_gnt1", ifb.p1_gnt, 0);
      if (k > 0) begin
        chk("ca_rv0",   ifa.p0_rvalid, ((k - 1) % 2) == 0);
        chk("ca_rv1",   ifa.p1_rvalid, ((k - 1) % 2) == 1);
        chk("ca_rdata", ifa.rdata, (((k - 1) % 2) == 0) ? 32'hC0DE0000 : 32'hC0DE0001);
        chk("cb_rv0",   ifb.p0_rvalid, 1);
        chk("cb_rv1",   ifb.p1_rvalid, 0);
      end
      tick();
    end
    ifa.p0_req = 0; ifb.p0_req = 0;
    mid();
    chk("ca5_gnt1", ifa.p1_gnt,    1);
    chk("ca5_rv1",  ifa.p1_rvalid, 1);
    chk("cb5_gnt1", ifb.p1_gnt,    1);
    chk("cb5_gnt0", ifb.p0_gnt,    0);
    chk("cb5_rv0",  ifb.p0_rvalid, 1);
    tick(); ifa.p1_req = 0; ifb.p1_req = 0;
    mid();
    chk("ca6_rv1",   ifa.p1_rvalid, 1);
    chk("ca6_rdata", ifa.rdata,     32'hC0DE0001);
    chk("cb6_rv1",   ifb.p1_rvalid, 1);
    chk("cb6_rv0",   ifb.p0_rvalid, 0);

    // write then read of the same word with a 2-cycle RAM
    tick();
    ifc.p0_req = 1; ifc.p0_we = 1; ifc.p0_addr = 8'h7F; ifc.p0_wdata = 32'h12345678;
    mid();
    chk("hz_gnt0",   ifc.p0_gnt, 1);
    chk("hz_mem_we", ifc.mem_we, 1);
    tick();
    ifc.p0_req = 0; ifc.p0_we = 0; ifc.p1_req = 1; ifc.p1_addr = 8'h7F;
    mid();
    chk("hz_gnt1",   ifc.p1_gnt,    1);
    chk("hz_wr_rv0", ifc.p0_rvalid, 0);
    tick(); ifc.p1_req = 0;
    mid();
    chk("hz_rv1_early", ifc.p1_rvalid, 0);
    tick(); mid();
    chk("hz_rv1",   ifc.p1_rvalid, 1);
    chk("hz_rdata", ifc.rdata,     32'h12345678);
    chk("hz_rv0",   ifc.p0_rvalid, 0);
    tick(); mid();
    chk("hz_rv1_end", ifc.p1_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port 256x32 block RAM.
- Shares the RAM between the core's load/store/fetch port (p0) and a second master (p1), such as the UART program loader or a debug reader.
- Grants at most one access per cycle, returns read data after a fixed RAM latency tagged to the owner, and supports locked bursts.
- Sits between the requesters and the RAM macro.

Parameters:
- AW, 8, word-address width (RAM depth 2^AW).
- DW, 32, data width.
- READ_LAT, 1, RAM read latency in cycles (1..4).
- RR, 1, 1 = round-robin on contention; 0 = fixed priority, p0 wins.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req  in  1  p0 access request; held until p0_gnt
- p0_we  in  1  p0 write enable, qualified by p0_req
- p0_lock  in  1  p0 requests to keep ownership after this grant
- p0_addr  in  AW  p0 word address
- p0_wdata  in  DW  p0 write data
- p0_gnt  out  1  p0 access accepted this cycle
- p0_rvalid  out  1  p0 read data valid on rdata
- p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_gnt, p1_rvalid  same as p0, for p1
- rdata  out  DW  read data, shared by both ports (= mem_dout)
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM read data, READ_LAT cycles after address

Behaviour:
- Reset (async, while rst=1):
  - State = IDLE; last = 1, so p0 wins first contention; read pipeline cleared.
  - p*_gnt = 0, p*_rvalid = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
- Grant is combinational in the cycle req is seen; gating by rst forces 0.
- In-flight reads at reset assertion are dropped: no rvalid after reset.
- States: IDLE, LOCK0, LOCK1.
- IDLE:
  - Only one req high -> grant it.
  - Both high, RR=1 -> grant the port != last.
  - Both high, RR=0 -> grant p0.
- LOCK0: only p0 may be granted; p1_gnt = 0 even if p1_req.
- LOCK1: mirror of LOCK0, only p1 may be granted.
- Transitions, evaluated each edge:
  - Grant to pN with pN_lock=1 -> LOCKN.
  - In LOCKN, leave to IDLE on the first edge where pN_req=0 or (pN granted with pN_lock=0).
- last <= granted port on every grant.
- Datapath:
  - mem_addr, mem_din = fields of the granted port; when no grant, they hold the previous values.
  - mem_we = gnt & we of the granted port.
- Reads: a granted access with we=0 enters a READ_LAT-deep shift register carrying {valid, owner}.
- At stage READ_LAT, pOwner_rvalid pulses for 1 cycle; rdata = mem_dout is combinational pass-through.
- Back-to-back reads: one per cycle sustained, possibly alternating owners; rvalid order equals grant order.
- Writes produce no rvalid; write-then-read to the same address on consecutive cycles returns the new data.
- p*_gnt and p*_rvalid are never high for both ports in the same cycle.
- Request dropped before grant: legal, no side effect.
- Request changed while not granted: the value at grant time is used.

Test Plan:
- Reset:
  - Assert rst mid-read (READ_LAT=1, p0 read of addr 0x10 granted the prior cycle) -> p0_rvalid stays 0; all outputs 0 during rst.
- Single reads:
  - p0 read 0x05 (RAM holds 0xDEADBEEF), p1 idle -> p0_gnt same cycle; p0_rvalid exactly 1 cycle later with rdata=0xDEADBEEF; p1_rvalid=0.
- Contention, RR=1:
  - Both req reads held 4 cycles after reset -> grants p0,p1,p0,p1.
  - rvalid sequence matches, 1 cycle delayed.
- Contention, RR=0:
  - Same stimulus -> p0 granted all 4 cycles; p1 granted in cycle 5 after p0_req drops.
- Lock:
  - p1 writes 0x00..0x03 with lock=1 on the first three, lock=0 on the last; p0_req high throughout -> p1 granted 4 consecutive cycles; p0_gnt=0 until cycle 5.
  - Readback by p0 gives the written values.
- Write/read hazard, READ_LAT=2:
  - p0 writes 0x7F=0x12345678, then p1 reads 0x7F next cycle -> p1_rvalid 2 cycles after its grant with rdata=0x12345678.
